// File: rtl/maxpool_2x2.sv
// Streaming 2x2 stride-2 max-pooling stage for a raster-order pixel stream.
// Even rows park their pairwise maxima in a half-row line buffer; odd rows finish each window.
`timescale 1ns/1ps
module maxpool_2x2 #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned IMG_WIDTH  = 8,
    parameter int unsigned IMG_HEIGHT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pixel_valid,
    input  logic [DATA_W-1:0] pixel_in,
    output logic              pool_valid,
    output logic [DATA_W-1:0] pool_out,
    output logic              frame_done
);

    localparam int unsigned COL_W    = (IMG_WIDTH  > 2) ? $clog2(IMG_WIDTH)  : 1;
    localparam int unsigned ROW_W    = (IMG_HEIGHT > 2) ? $clog2(IMG_HEIGHT) : 1;
    localparam int unsigned LB_DEPTH = IMG_WIDTH / 2;
    localparam int unsigned IDX_W    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

    logic [COL_W-1:0]  r_col;
    logic [ROW_W-1:0]  r_row;
    logic [DATA_W-1:0] r_h;
    logic [DATA_W-1:0] r_linebuf [LB_DEPTH];

    logic [IDX_W-1:0]  w_idx;
    logic [DATA_W-1:0] w_lb_rd;
    logic [DATA_W-1:0] w_hmax;
    logic [DATA_W-1:0] w_vmax;
    logic              w_last_col;
    logic              w_last_row;

    assign w_idx      = IDX_W'(r_col >> 1);
    assign w_lb_rd    = r_linebuf[w_idx];
    assign w_hmax     = (pixel_in > r_h) ? pixel_in : r_h;
    assign w_vmax     = (w_lb_rd > w_hmax) ? w_lb_rd : w_hmax;
    assign w_last_col = (r_col == COL_W'(IMG_WIDTH - 1));
    assign w_last_row = (r_row == ROW_W'(IMG_HEIGHT - 1));

    // Position counters, horizontal hold and registered window output.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_col      <= '0;
            r_row      <= '0;
            r_h        <= '0;
            pool_valid <= 1'b0;
            pool_out   <= '0;
            frame_done <= 1'b0;
        end else begin
            pool_valid <= 1'b0;
            frame_done <= 1'b0;
            if (pixel_valid) begin
                if (!r_col[0]) begin
                    r_h <= pixel_in;
                end else if (r_row[0]) begin
                    pool_out   <= w_vmax;
                    pool_valid <= 1'b1;
                    frame_done <= w_last_row && w_last_col;
                end

                if (w_last_col) begin
                    r_col <= '0;
                    r_row <= w_last_row ? '0 : r_row + ROW_W'(1);
                end else begin
                    r_col <= r_col + COL_W'(1);
                end
            end
        end
    end

    // Line buffer is always written before read within a frame, so it carries no reset.
    always_ff @(posedge clk) begin
        if (!rst && pixel_valid && r_col[0] && !r_row[0]) begin
            r_linebuf[w_idx] <= w_hmax;
        end
    end

endmodule

// File: tb/tb_maxpool_2x2.sv
// Directed bench for maxpool_2x2 on a 4x4 frame with hand-computed window maxima.
`timescale 1ns/1ps
module tb_maxpool_2x2;

    logic       clk = 1'b0;
    logic       rst;
    logic       pixel_valid;
    logic [7:0] pixel_in;
    logic       pool_valid;
    logic [7:0] pool_out;
    logic       frame_done;

    int checks   = 0;
    int failures = 0;

    logic [7:0] pix     [16];
    logic [7:0] exp_win [4];
    logic [7:0] exp_last;

    maxpool_2x2 #(.DATA_W(8), .IMG_WIDTH(4), .IMG_HEIGHT(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .pixel_valid (pixel_valid),
        .pixel_in    (pixel_in),
        .pool_valid  (pool_valid),
        .pool_out    (pool_out),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, then check outputs #1 after the edge.
    task automatic step(input logic v, input logic [7:0] d,
                        input logic e_v, input logic [7:0] e_o, input logic e_fd);
        pixel_valid = v;
        pixel_in    = d;
        @(posedge clk);
        #1;
        if (e_v) exp_last = e_o;
        chk("pool_valid", 32'(pool_valid), 32'(e_v));
        chk("frame_done", 32'(frame_done), 32'(e_fd));
        chk("pool_out",   32'(pool_out),   32'(exp_last));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 8'hA5, 1'b0, 8'h00, 1'b0);
    endtask

    // Stream pix[] as one frame; windows complete at pixel indices 5, 7, 13, 15.
    task automatic run_frame(input bit gaps);
        for (int i = 0; i < 16; i++) begin
            if (gaps && ($urandom_range(0, 1) == 1)) idle(int'($urandom_range(2, 5)));
            case (i)
                5:       step(1'b1, pix[i], 1'b1, exp_win[0], 1'b0);
                7:       step(1'b1, pix[i], 1'b1, exp_win[1], 1'b0);
                13:      step(1'b1, pix[i], 1'b1, exp_win[2], 1'b0);
                15:      step(1'b1, pix[i], 1'b1, exp_win[3], 1'b1);
                default: step(1'b1, pix[i], 1'b0, 8'h00,      1'b0);
            endcase
        end
    endtask

    task automatic load_ramp();
        for (int i = 0; i < 16; i++) pix[i] = 8'(i + 1);
        exp_win[0] = 8'd6;  exp_win[1] = 8'd8;
        exp_win[2] = 8'd14; exp_win[3] = 8'd16;
    endtask

    initial begin
        rst         = 1'b1;
        pixel_valid = 1'b1;
        pixel_in    = 8'hFF;
        exp_last    = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_pool_valid", 32'(pool_valid), 32'd0);
        chk("reset_pool_out",   32'(pool_out),   32'd0);
        chk("reset_frame_done", 32'(frame_done), 32'd0);
        rst = 1'b0;

        // Ramp frame, back-to-back.
        load_ramp();
        run_frame(1'b0);
        idle(2);

        // Unsigned max and position: rows 0-1 {01,FF,80,7F} and {00,00,00,FE}; rows 2-3 {00,03,FF,FE} and {10,20,30,05}.
        pix[0]  = 8'h01; pix[1]  = 8'hFF; pix[2]  = 8'h00; pix[3]  = 8'h00;
        pix[4]  = 8'h80; pix[5]  = 8'h7F; pix[6]  = 8'h00; pix[7]  = 8'hFE;
        pix[8]  = 8'h00; pix[9]  = 8'h03; pix[10] = 8'h10; pix[11] = 8'h20;
        pix[12] = 8'hFF; pix[13] = 8'hFE; pix[14] = 8'h30; pix[15] = 8'h05;
        exp_win[0] = 8'hFF; exp_win[1] = 8'hFE; exp_win[2] = 8'hFF; exp_win[3] = 8'h30;
        run_frame(1'b0);

        // Ramp with random idle gaps.
        load_ramp();
        run_frame(1'b1);

        // Back-to-back: ramp, ramp, descending, no idle between frames.
        run_frame(1'b0);
        run_frame(1'b0);
        for (int i = 0; i < 16; i++) pix[i] = 8'(16 - i);
        exp_win[0] = 8'd16; exp_win[1] = 8'd14; exp_win[2] = 8'd8; exp_win[3] = 8'd6;
        run_frame(1'b0);

        // Reset mid-frame: pixels 1..7 (6 completes a window), then reset with a valid pixel that must be dropped.
        for (int i = 1; i <= 7; i++) begin
            if (i == 6) step(1'b1, 8'(i), 1'b1, 8'd6, 1'b0);
            else        step(1'b1, 8'(i), 1'b0, 8'h00, 1'b0);
        end
        rst = 1'b1;
        exp_last = 8'h00;
        step(1'b1, 8'd8, 1'b0, 8'h00, 1'b0);
        rst = 1'b0;
        idle(1);
        load_ramp();
        run_frame(1'b0);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
